half_packer: RTL

HALF_PACKER -- requirements
Module: half_packer

---
 rtl/half_packer_if.sv | 23 ++
 rtl/half_packer.sv | 152 +++++++++++++++
 2 files changed

// File: rtl/half_packer_if.sv
// Handshake bundle for half_packer: operand in, packed IEEE-754 half out.
interface half_packer_if;
  logic        in_valid;
  logic        in_ready;
  logic        s_in;
  logic [4:0]  e_in;
  logic [14:0] m_in;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out;
  logic        ovf;
  logic        unf;

  modport master (
    output in_valid, s_in, e_in, m_in, out_ready,
    input  in_ready, out_valid, out, ovf, unf
  );

  modport slave (
    input  in_valid, s_in, e_in, m_in, out_ready,
    output in_ready, out_valid, out, ovf, unf
  );
endinterface

// File: rtl/half_packer.sv
// Normalizes, rounds and packs an unnormalized sign/exponent/mantissa into IEEE-754 half.
// Define HALF_PACKER_ROUND_NEAREST_EN for round-to-nearest-even; otherwise results are truncated.
module half_packer (
  input  logic         clk,
  input  logic         rst_n,
  half_packer_if.slave bus
);

`ifdef HALF_PACKER_ROUND_NEAREST_EN
  localparam bit RNE = 1'b1;
`else
  localparam bit RNE = 1'b0;
`endif

  typedef enum logic [1:0] {IDLE, NORM, ROUND, DONE} state_t;
  typedef enum logic [1:0] {CLS_NUM, CLS_ZERO, CLS_INF, CLS_UNF} cls_t;

  state_t      state, state_nxt;
  cls_t        cls, cls_nxt;
  logic        sgn, sgn_nxt;
  logic [5:0]  exp_r, exp_nxt, exp_rnd;
  logic [14:0] man, man_nxt;
  logic [15:0] res, res_nxt;
  logic        ovf_r, ovf_nxt;
  logic        unf_r, unf_nxt;
  logic        vld, vld_nxt;
  logic [11:0] rnd;
  logic [9:0]  frac;

  // Returns mantissa bits 14:3 after rounding; bit 11 of the result is the rounding carry.
  function automatic logic [11:0] round_mant(input logic [13:0] m);
    logic inc;
    inc = RNE & m[2] & (m[1] | m[0] | m[3]);
    return {1'b0, m[13:3]} + {11'd0, inc};
  endfunction

  always_comb begin
    state_nxt = state;
    cls_nxt   = cls;
    sgn_nxt   = sgn;
    exp_nxt   = exp_r;
    man_nxt   = man;
    res_nxt   = res;
    ovf_nxt   = ovf_r;
    unf_nxt   = unf_r;
    vld_nxt   = vld;
    rnd       = round_mant(man[13:0]);
    exp_rnd   = exp_r + {5'd0, rnd[11]};
    frac      = rnd[11] ? rnd[10:1] : rnd[9:0];

    unique case (state)
      IDLE: begin
        if (bus.in_valid) begin
          state_nxt = NORM;
          sgn_nxt   = bus.s_in;
          exp_nxt   = {1'b0, bus.e_in};
          man_nxt   = bus.m_in;
          if (bus.m_in == 15'd0 || bus.e_in == 5'd0)
            cls_nxt = CLS_ZERO;
          else if (bus.e_in == 5'd31)
            cls_nxt = CLS_INF;
          else
            cls_nxt = CLS_NUM;
        end
      end

      NORM: begin
        if (cls != CLS_NUM) begin
          state_nxt = ROUND;
        end else if (man[14]) begin
          // Carry out: shift right, folding the dropped bit into sticky.
          man_nxt = {1'b0, man[14:2], man[1] | man[0]};
          exp_nxt = exp_r + 6'd1;
        end else if (man[13]) begin
          state_nxt = ROUND;
        end else if (exp_r > 6'd1) begin
          man_nxt = {man[13:0], 1'b0};
          exp_nxt = exp_r - 6'd1;
        end else begin
          cls_nxt   = CLS_UNF;
          state_nxt = ROUND;
        end
      end

      ROUND: begin
        state_nxt = DONE;
        vld_nxt   = 1'b1;
        ovf_nxt   = 1'b0;
        unf_nxt   = 1'b0;
        case (cls)
          CLS_ZERO: res_nxt = {sgn, 15'd0};
          CLS_INF: begin
            res_nxt = {sgn, 5'h1F, 10'd0};
            ovf_nxt = 1'b1;
          end
          CLS_UNF: begin
            res_nxt = {sgn, 15'd0};
            unf_nxt = 1'b1;
          end
          default: begin
            man_nxt = rnd[11] ? {1'b0, rnd, 2'b00} : {rnd, 3'b000};
            exp_nxt = exp_rnd;
            if (exp_rnd >= 6'd31) begin
              res_nxt = {sgn, 5'h1F, 10'd0};
              ovf_nxt = 1'b1;
            end else begin
              res_nxt = {sgn, exp_rnd[4:0], frac};
            end
          end
        endcase
      end

      DONE: begin
        if (bus.out_ready) begin
          state_nxt = IDLE;
          vld_nxt   = 1'b0;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cls   <= CLS_NUM;
      sgn   <= 1'b0;
      exp_r <= 6'd0;
      man   <= 15'd0;
      res   <= 16'h0000;
      ovf_r <= 1'b0;
      unf_r <= 1'b0;
      vld   <= 1'b0;
    end else begin
      state <= state_nxt;
      cls   <= cls_nxt;
      sgn   <= sgn_nxt;
      exp_r <= exp_nxt;
      man   <= man_nxt;
      res   <= res_nxt;
      ovf_r <= ovf_nxt;
      unf_r <= unf_nxt;
      vld   <= vld_nxt;
    end
  end

  assign bus.in_ready  = (state == IDLE) && rst_n;
  assign bus.out_valid = vld;
  assign bus.out       = res;
  assign bus.ovf       = ovf_r;
  assign bus.unf       = unf_r;

endmodule
